// File: rtl/shadow_regs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : shadow_regs_pkg                                         |
// | Description : Shadow-register frame layout shared by the save and     |
// |               restore paths so the two can never disagree.            |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
package shadow_regs_pkg;

  localparam int NUM_SHADOW_SAVES = 16;

  // Frame word positions of the two CSRs; GPRs follow from word 2 onward.
  localparam int FRAME_MEPC_IDX   = 0;
  localparam int FRAME_MCAUSE_IDX = 1;
  localparam int FRAME_GPR_BASE   = 2;

  localparam int NUM_RESTORE_GPRS = 14;

  // GPR number held in frame word (FRAME_GPR_BASE + i); element 0 is the
  // rightmost item. x0 is deliberately absent.
  localparam logic [NUM_RESTORE_GPRS-1:0][4:0] RESTORE_MAP = {
    5'd29, 5'd28, 5'd17, 5'd16, 5'd15, 5'd14, 5'd13,
    5'd12, 5'd11, 5'd10, 5'd7,  5'd6,  5'd5,  5'd1
  };

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SAVE = 3'd1,
    LOAD      = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4
  } restore_state_e;

  // Out-of-table indices return x0 so a stray lookup can never hit a live GPR.
  function automatic logic [4:0] restore_map_lookup(input logic [3:0] idx);
    logic [4:0] r_gpr;
    r_gpr = 5'd0;
    if (idx < 4'(NUM_RESTORE_GPRS)) begin
      r_gpr = RESTORE_MAP[idx];
    end
    return r_gpr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shadow_register_restorer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : shadow_register_restorer_if                             |
// | Description : Dedicated dcache load port used to pop a saved frame.   |
// |               Responses return in request order.                      |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
interface shadow_register_restorer_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int PADDR_WIDTH = 56
);

  logic                   ld_req_o;
  logic [PADDR_WIDTH-1:0] ld_addr_o;
  logic                   ld_gnt_i;
  logic                   ld_rvalid_i;
  logic [DATA_WIDTH-1:0]  ld_rdata_i;

  // Restorer side issues requests and consumes data.
  modport master (
    output ld_req_o,
    output ld_addr_o,
    input  ld_gnt_i,
    input  ld_rvalid_i,
    input  ld_rdata_i
  );

  // Dcache side grants requests and returns data.
  modport slave (
    input  ld_req_o,
    input  ld_addr_o,
    output ld_gnt_i,
    output ld_rvalid_i,
    output ld_rdata_i
  );

endinterface
`default_nettype wire

// File: rtl/shadow_register_restorer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : shadow_register_restorer                                |
// | Description : On mret with a non-zero save level, pops one frame via  |
// |               the dcache load port, writes mepc/mcause and the GPRs   |
// |               back, stalls issue meanwhile and publishes the popped   |
// |               stack pointer.                                          |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module shadow_register_restorer
  import shadow_regs_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 5,
  parameter int NUM_ENTRIES     = 16,
  parameter int MAX_OUTSTANDING = 2,
  parameter int PADDR_WIDTH     = 56
) (
  input  wire                          clk_i,
  input  wire                          rst_i,
  input  wire                          restore_req_i,
  input  wire                          save_busy_i,
  input  wire  [4:0]                   save_level_i,
  input  wire  [DATA_WIDTH-1:0]        frame_sp_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         level_dec_o,
  output logic [DATA_WIDTH-1:0]        next_sp_o,
  shadow_register_restorer_if.master   ld,
  output logic                         rf_we_o,
  output logic [ADDR_WIDTH-1:0]        rf_waddr_o,
  output logic [DATA_WIDTH-1:0]        rf_wdata_o,
  output logic                         csr_mepc_we_o,
  output logic                         csr_mcause_we_o,
  output logic [DATA_WIDTH-1:0]        csr_wdata_o
);

  localparam int c_WORD_BYTES = DATA_WIDTH / 8;
  localparam int c_IDX_W      = $clog2(NUM_ENTRIES + 1);
  localparam int c_OUT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [DATA_WIDTH-1:0] c_FRAME_BYTES =
    DATA_WIDTH'(NUM_ENTRIES * c_WORD_BYTES);

  restore_state_e         r_state;
  restore_state_e         w_next_state;
  logic [DATA_WIDTH-1:0]  r_base;
  logic [c_IDX_W-1:0]     r_issue_idx;
  logic [c_IDX_W-1:0]     r_resp_idx;
  logic [c_OUT_W-1:0]     r_outstanding;
  logic                   r_rsp_valid;
  logic [c_IDX_W-1:0]     r_rsp_slot;
  logic [DATA_WIDTH-1:0]  r_rsp_data;

  logic                   w_start;
  logic                   w_req;
  logic                   w_fire;
  logic                   w_rsp_acc;
  logic [DATA_WIDTH-1:0]  w_addr_full;
  logic [3:0]             w_map_idx;
  logic                   w_is_mepc;
  logic                   w_is_mcause;
  logic                   w_is_gpr;

  // A request with save level 0 has nothing to pop and is dropped.
  assign w_start = (r_state == IDLE) && restore_req_i && (save_level_i != 5'd0);

  // Request stays asserted (and address stable) until granted, because
  // issue_idx and the outstanding count only move on grant/response.
  assign w_req = (r_state == LOAD)
              && (r_issue_idx < c_IDX_W'(NUM_ENTRIES))
              && (r_outstanding < c_OUT_W'(MAX_OUTSTANDING));
  assign w_fire = w_req && ld.ld_gnt_i;

  // Responses with nothing outstanding (e.g. in flight across a reset) are dropped.
  assign w_rsp_acc = ld.ld_rvalid_i && (r_outstanding != '0);

  assign w_addr_full = r_base + (DATA_WIDTH'(r_issue_idx) * DATA_WIDTH'(c_WORD_BYTES));
  assign ld.ld_req_o  = w_req;
  assign ld.ld_addr_o = w_req ? PADDR_WIDTH'(w_addr_full) : '0;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_next_state = save_busy_i ? WAIT_SAVE : LOAD;
        end
      end
      WAIT_SAVE: begin
        if (!save_busy_i) begin
          w_next_state = LOAD;
        end
      end
      LOAD: begin
        if (r_issue_idx == c_IDX_W'(NUM_ENTRIES)) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        // resp_idx reaches the end on the edge that registers the last
        // write, so the final write pulse is already out when DONE begins.
        if (r_resp_idx == c_IDX_W'(NUM_ENTRIES)) begin
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Frame base, issue/response indices and outstanding-request count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_base        <= '0;
      r_issue_idx   <= '0;
      r_resp_idx    <= '0;
      r_outstanding <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_issue_idx <= '0;
        r_resp_idx  <= '0;
        if (restore_req_i) begin
          r_base <= frame_sp_i;
        end
      end else begin
        if (w_fire) begin
          r_issue_idx <= r_issue_idx + c_IDX_W'(1);
        end
        if (w_rsp_acc) begin
          r_resp_idx <= r_resp_idx + c_IDX_W'(1);
        end
      end
      case ({w_fire, w_rsp_acc})
        2'b10:   r_outstanding <= r_outstanding + c_OUT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - c_OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Register each accepted response together with its frame slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_slot  <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_rsp_acc;
      if (w_rsp_acc) begin
        r_rsp_slot <= r_resp_idx;
        r_rsp_data <= ld.ld_rdata_i;
      end
    end
  end

  assign w_is_mepc   = r_rsp_valid && (r_rsp_slot == c_IDX_W'(FRAME_MEPC_IDX));
  assign w_is_mcause = r_rsp_valid && (r_rsp_slot == c_IDX_W'(FRAME_MCAUSE_IDX));
  assign w_is_gpr    = r_rsp_valid && (r_rsp_slot >= c_IDX_W'(FRAME_GPR_BASE));
  assign w_map_idx   = 4'(r_rsp_slot - c_IDX_W'(FRAME_GPR_BASE));

  assign csr_mepc_we_o   = w_is_mepc;
  assign csr_mcause_we_o = w_is_mcause;
  assign csr_wdata_o     = (w_is_mepc || w_is_mcause) ? r_rsp_data : '0;

  assign rf_we_o    = w_is_gpr;
  assign rf_waddr_o = w_is_gpr ? ADDR_WIDTH'(restore_map_lookup(w_map_idx)) : '0;
  assign rf_wdata_o = w_is_gpr ? r_rsp_data : '0;

  assign busy_o      = (r_state != IDLE);
  assign done_o      = (r_state == DONE);
  assign level_dec_o = (r_state == DONE);
  assign next_sp_o   = (r_state == DONE) ? (r_base + c_FRAME_BYTES) : '0;

endmodule
`default_nettype wire

// File: tb/tb_shadow_register_restorer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_shadow_register_restorer                             |
// | Description : Self-checking bench: table of full restores plus a      |
// |               hand-written reset-mid-restore sequence.                |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module tb_shadow_register_restorer;

  localparam int DW = 64;
  localparam int PW = 56;
  localparam int AW = 5;
  localparam int MO = 2;

  typedef struct {
    logic [63:0] sp;
    logic [4:0]  level;
    int          busy_cyc;
    int          lat;
    int          gnt_mod;
    logic        exp_restore;
    logic [63:0] exp_next_sp;
  } vec_t;

  typedef struct {
    logic [PW-1:0] addr;
    int            due;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          restore_req;
  logic          save_busy;
  logic [4:0]    save_level;
  logic [DW-1:0] frame_sp;
  logic          busy_o, done_o, level_dec_o;
  logic [DW-1:0] next_sp_o;
  logic          rf_we_o, csr_mepc_we_o, csr_mcause_we_o;
  logic [AW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdata_o, csr_wdata_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lat = 2;
  int gnt_mod = 1;
  logic [63:0] cur_sp = '0;

  int exp_map [14] = '{1, 5, 6, 7, 10, 11, 12, 13, 14, 15, 16, 17, 28, 29};

  vec_t vecs [5];
  rsp_t rq [$];

  // monitor state
  int m_gcnt, m_req_cyc, m_addr_err, m_stab_err, m_rf_cnt, m_rf_err;
  int m_mepc_cnt, m_mcause_cnt, m_done_cnt, m_bad_busy, m_sp_err, m_ws_err;
  int m_busy_cyc, m_max_occ;
  int m_wr_any = 0;
  int m_done_any = 0;
  logic [63:0] m_mepc_data, m_mcause_data, m_done_sp;
  logic m_done_ldec;
  logic p_wait = 1'b0;
  logic p_done = 1'b0;
  logic p_save_busy = 1'b0;
  logic [PW-1:0] p_addr = '0;

  shadow_register_restorer_if #(.DATA_WIDTH(DW), .PADDR_WIDTH(PW)) ld_if ();

  shadow_register_restorer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ENTRIES(16),
    .MAX_OUTSTANDING(MO), .PADDR_WIDTH(PW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .restore_req_i(restore_req),
    .save_busy_i(save_busy), .save_level_i(save_level), .frame_sp_i(frame_sp),
    .busy_o(busy_o), .done_o(done_o), .level_dec_o(level_dec_o),
    .next_sp_o(next_sp_o), .ld(ld_if),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .csr_mepc_we_o(csr_mepc_we_o), .csr_mcause_we_o(csr_mcause_we_o),
    .csr_wdata_o(csr_wdata_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign ld_if.ld_gnt_i = ld_if.ld_req_o && ((cyc % gnt_mod) == 0);

  function automatic logic [63:0] word_of(input logic [63:0] a);
    return {8'h5A, a[55:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Observe DUT outputs mid-cycle, then act as the in-order dcache.
  always @(negedge clk) begin : mon
    logic [63:0] ea;
    int occ;
    if (restore_req) begin
      m_gcnt = 0; m_req_cyc = 0; m_addr_err = 0; m_stab_err = 0;
      m_rf_cnt = 0; m_rf_err = 0; m_mepc_cnt = 0; m_mcause_cnt = 0;
      m_done_cnt = 0; m_bad_busy = 0; m_sp_err = 0; m_ws_err = 0;
      m_busy_cyc = 0; m_max_occ = 0; m_mepc_data = '0; m_mcause_data = '0;
      m_done_sp = '0; m_done_ldec = 1'b0;
    end
    if (ld_if.ld_req_o) m_req_cyc++;
    if (p_wait && (!ld_if.ld_req_o || ld_if.ld_addr_o !== p_addr)) m_stab_err++;
    p_wait = ld_if.ld_req_o && !ld_if.ld_gnt_i;
    p_addr = ld_if.ld_addr_o;
    if (ld_if.ld_req_o && ld_if.ld_gnt_i) begin
      ea = cur_sp + 64'(m_gcnt) * 64'd8;
      if (ld_if.ld_addr_o !== ea[PW-1:0]) m_addr_err++;
      m_gcnt++;
    end
    if ((save_busy || p_save_busy) && ld_if.ld_req_o) m_ws_err++;
    if (save_busy && !restore_req && !busy_o) m_ws_err++;
    p_save_busy = save_busy;
    if (rf_we_o) begin
      if (m_rf_cnt < 14) begin
        ea = cur_sp + 64'(m_rf_cnt + 2) * 64'd8;
        if (rf_waddr_o !== AW'(exp_map[m_rf_cnt]) || rf_wdata_o !== word_of(ea)) m_rf_err++;
      end else begin
        m_rf_err++;
      end
      m_rf_cnt++;
      m_wr_any++;
    end
    if (csr_mepc_we_o) begin m_mepc_cnt++; m_mepc_data = csr_wdata_o; m_wr_any++; end
    if (csr_mcause_we_o) begin m_mcause_cnt++; m_mcause_data = csr_wdata_o; m_wr_any++; end
    if (done_o) begin
      m_done_cnt++; m_done_any++; m_done_sp = next_sp_o; m_done_ldec = level_dec_o;
    end
    if (!done_o && next_sp_o != '0) m_sp_err++;
    if (p_done && busy_o) m_bad_busy++;
    p_done = done_o;
    if (busy_o) m_busy_cyc++;

    // dcache responder
    if (ld_if.ld_rvalid_i && rq.size() > 0) void'(rq.pop_front());
    if (ld_if.ld_req_o && ld_if.ld_gnt_i) rq.push_back('{addr: ld_if.ld_addr_o, due: cyc + lat});
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      ld_if.ld_rvalid_i = 1'b1;
      ld_if.ld_rdata_i  = word_of({8'h00, rq[0].addr});
    end else begin
      ld_if.ld_rvalid_i = 1'b0;
      ld_if.ld_rdata_i  = '0;
    end
    occ = rq.size() - (ld_if.ld_rvalid_i ? 1 : 0);
    if (occ > m_max_occ) m_max_occ = occ;
  end

  task automatic run_vec(input vec_t v, input string tag);
    int t;
    lat = v.lat;
    gnt_mod = v.gnt_mod;
    @(posedge clk); #1;
    restore_req = 1'b1; frame_sp = v.sp; save_level = v.level;
    save_busy = (v.busy_cyc > 0); cur_sp = v.sp;
    @(posedge clk); #1;
    restore_req = 1'b0; frame_sp = '1;
    @(negedge clk);
    chk({tag, "_busy_after_req"}, 64'(busy_o), 64'(v.exp_restore));
    if (v.busy_cyc > 0) begin
      repeat (v.busy_cyc - 1) @(posedge clk);
      #1 save_busy = 1'b0;
    end
    if (v.exp_restore) begin
      t = 0;
      while (m_done_cnt == 0 && t < 600) begin @(negedge clk); t++; end
      chk({tag, "_done_seen"}, 64'(m_done_cnt > 0), 64'd1);
      @(negedge clk);
      chk({tag, "_next_sp"}, m_done_sp, v.exp_next_sp);
      chk({tag, "_level_dec"}, 64'(m_done_ldec), 64'd1);
      chk({tag, "_done_count"}, 64'(m_done_cnt), 64'd1);
      chk({tag, "_mepc"}, m_mepc_data, word_of(v.sp));
      chk({tag, "_mcause"}, m_mcause_data, word_of(v.sp + 64'd8));
      chk({tag, "_csr_counts"}, 64'({m_mepc_cnt[7:0], m_mcause_cnt[7:0]}), 64'h0101);
      chk({tag, "_rf_count"}, 64'(m_rf_cnt), 64'd14);
      chk({tag, "_rf_errs"}, 64'(m_rf_err), 64'd0);
      chk({tag, "_grants"}, 64'(m_gcnt), 64'd16);
      chk({tag, "_addr_errs"}, 64'(m_addr_err), 64'd0);
      chk({tag, "_addr_stable_errs"}, 64'(m_stab_err), 64'd0);
      chk({tag, "_max_outstanding_ok"}, 64'(m_max_occ <= MO), 64'd1);
      chk({tag, "_busy_after_done"}, 64'(m_bad_busy), 64'd0);
      chk({tag, "_wait_save_errs"}, 64'(m_ws_err), 64'd0);
      chk({tag, "_next_sp_outside_done"}, 64'(m_sp_err), 64'd0);
    end else begin
      repeat (30) @(negedge clk);
      chk({tag, "_busy_cycles"}, 64'(m_busy_cyc), 64'd0);
      chk({tag, "_req_cycles"}, 64'(m_req_cyc), 64'd0);
      chk({tag, "_done_count"}, 64'(m_done_cnt), 64'd0);
      chk({tag, "_writes"}, 64'(m_rf_cnt + m_mepc_cnt + m_mcause_cnt), 64'd0);
    end
  endtask

  initial begin : main
    vec_t mid_v;
    int t;
    int w0;
    int d0;
    int base_wr;
    rst = 1'b1; restore_req = 1'b0; save_busy = 1'b0; save_level = '0; frame_sp = '0;

    //          sp                        lvl busy lat gnt exp  next_sp
    vecs[0] = '{64'h0000_0000_8000_1000, 5'd1, 0,  2,  1, 1'b1, 64'h0000_0000_8000_1080};
    vecs[1] = '{64'h0000_0000_8000_2000, 5'd3, 0, 10,  1, 1'b1, 64'h0000_0000_8000_2080};
    vecs[2] = '{64'h0000_0000_1234_5600, 5'd2, 5,  3,  3, 1'b1, 64'h0000_0000_1234_5680};
    vecs[3] = '{64'h0000_0000_8000_3000, 5'd0, 0,  2,  1, 1'b0, 64'h0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFC0, 5'd1, 0,  1,  2, 1'b1, 64'h0000_0000_0000_0040};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 64'({busy_o, done_o, level_dec_o, ld_if.ld_req_o, rf_we_o,
                           csr_mepc_we_o, csr_mcause_we_o}), 64'd0);
    chk("reset_data", next_sp_o | rf_wdata_o | csr_wdata_o | 64'(rf_waddr_o)
                      | 64'(ld_if.ld_addr_o), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a restore, then restart the same frame.
    lat = 2; gnt_mod = 1;
    base_wr = m_wr_any;
    @(posedge clk); #1;
    restore_req = 1'b1; frame_sp = 64'h0000_0000_8000_4000; save_level = 5'd1;
    save_busy = 1'b0; cur_sp = 64'h0000_0000_8000_4000;
    @(posedge clk); #1 restore_req = 1'b0;
    t = 0;
    while ((m_wr_any - base_wr) < 7 && t < 200) begin @(negedge clk); t++; end
    chk("mid_reached_7_writes", 64'((m_wr_any - base_wr) >= 7), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_ctrl", 64'({busy_o, done_o, level_dec_o, ld_if.ld_req_o, rf_we_o,
                               csr_mepc_we_o, csr_mcause_we_o}), 64'd0);
    chk("mid_reset_data", next_sp_o | rf_wdata_o | csr_wdata_o | 64'(rf_waddr_o)
                          | 64'(ld_if.ld_addr_o), 64'd0);
    rst = 1'b0;
    w0 = m_wr_any;
    d0 = m_done_any;
    repeat (20) @(negedge clk);
    chk("mid_stray_writes", 64'(m_wr_any - w0), 64'd0);
    chk("mid_stray_done", 64'(m_done_any - d0), 64'd0);

    mid_v = '{64'h0000_0000_8000_4000, 5'd1, 0, 2, 1, 1'b1, 64'h0000_0000_8000_4080};
    run_vec(mid_v, "restart");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
